// File: rtl/lsu_mem_if_if.sv
// Bundle of the request, response and memory-side signals of the load/store unit.
// The slave modport is the LSU; the master modport is the core plus memory around it.
interface lsu_mem_if_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd_strobe;
    logic [3:0]  mem_wr_strobe;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_addr, mem_wdata, mem_rd_strobe, mem_wr_strobe
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_addr, mem_wdata, mem_rd_strobe, mem_wr_strobe
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns one RV32I byte/half/word request into an aligned, lane-strobed
// memory access and returns extended load data, store completion or an error response.
module lsu_mem_if (
    input  logic        clk,
    input  logic        rst,
    lsu_mem_if_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LWAIT  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        err_q, err_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        legal;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata_rep;
    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign accept = bus.req_valid & (state_q == IDLE);

    // funct3 3 and 6/7 are never legal; BU/HU only exist as loads.
    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~bus.req_addr[0];
            3'd2:    legal = (bus.req_addr[1:0] == 2'b00);
            3'd4:    legal = ~bus.req_we;
            3'd5:    legal = ~bus.req_we & ~bus.req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_mask[gi] =
                (bus.req_funct3[1:0] == 2'd0) ? (bus.req_addr[1:0] == 2'(gi)) :
                (bus.req_funct3[1:0] == 2'd1) ? (bus.req_addr[1] == 1'(gi / 2)) :
                (bus.req_funct3[1:0] == 2'd2);
            assign req_wdata_rep[8*gi +: 8] =
                (bus.req_funct3[1:0] == 2'd0) ? bus.req_wdata[7:0] :
                (bus.req_funct3[1:0] == 2'd1) ? bus.req_wdata[8*(gi % 2) +: 8] :
                                                bus.req_wdata[8*gi +: 8];
        end
    endgenerate

    assign ld_shifted = bus.mem_rdata >> {lane_q, 3'b000};
    assign ld_byte    = ld_shifted[7:0];
    assign ld_half    = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        ld_ext = 32'h0;
        case (funct3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd2:    ld_ext = bus.mem_rdata;
            3'd4:    ld_ext = {24'h0, ld_byte};
            3'd5:    ld_ext = {16'h0, ld_half};
            default: ld_ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        err_d       = err_q;
        wmask_d     = wmask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE:    if (accept) state_d = legal ? ACCESS : RESP;
            ACCESS:  state_d = we_q ? RESP : LWAIT;
            LWAIT:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            we_d        = bus.req_we;
            funct3_d    = bus.req_funct3;
            lane_d      = bus.req_addr[1:0];
            err_d       = ~legal;
            wmask_d     = req_mask;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wdata_d = req_wdata_rep;
        end

        // Read data only changes when a response is about to be presented.
        if ((state_d == RESP) && (state_q != RESP)) begin
            rsp_rdata_d = (state_q == LWAIT) ? ld_ext : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            err_q       <= 1'b0;
            wmask_q     <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            err_q       <= err_d;
            wmask_q     <= wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_err       = (state_q == RESP) & err_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    // Strobes are masked by reset so an aborted access can never reach memory.
    assign bus.mem_rd_strobe = ~rst & (state_q == ACCESS) & ~we_q;
    assign bus.mem_wr_strobe = (~rst && (state_q == ACCESS) && we_q) ? wmask_q : 4'h0;
endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: byte-array reference model, behavioural 1-cycle memory,
// directed scenarios and randomized requests.
module tb_lsu_mem_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_if_if bus ();
    lsu_mem_if dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ref_mem   [0:255];
    logic [31:0] mem_words [0:63];

    function automatic logic [31:0] init_word(input int i);
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0F0F;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem_words[i] <= init_word(i);
    end

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_wr_strobe[b])
                mem_words[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        if (bus.mem_rd_strobe) bus.mem_rdata <= mem_words[bus.mem_addr[7:2]];
    end

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic e_err, output int e_lat,
                         output logic [31:0] e_rdata, output logic [3:0] e_wstrb,
                         output logic [31:0] e_wdata);
        int nbytes, off;
        logic ok;
        longint v;
        ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = 1 << f3[1:0];
        off = int'(addr[1:0]);
        if (ok && ((off % nbytes) != 0)) ok = 1'b0;
        e_err = ~ok;
        e_lat = !ok ? 1 : (we ? 2 : 3);
        e_rdata = 32'h0;
        e_wstrb = 4'h0;
        e_wdata = 32'h0;
        if (ok && we) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + nbytes) e_wstrb[b] = 1'b1;
                e_wdata[8*b +: 8] = wdata[8*(b % nbytes) +: 8];
            end
            for (int i = 0; i < nbytes; i++) ref_mem[(int'(addr) + i) & 255] = wdata[8*i +: 8];
        end
        if (ok && !we) begin
            v = 0;
            for (int i = 0; i < nbytes; i++)
                v += longint'(ref_mem[(int'(addr) + i) & 255]) << (8 * i);
            if (f3 < 3'd4 && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
                v -= (longint'(1) << (8 * nbytes));
            e_rdata = v[31:0];
        end
    endtask

    // Issues one request at a negedge and observes it up to one cycle past the response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic g_err, output int g_lat,
                          output logic [31:0] g_rdata, output logic [3:0] g_wstrb,
                          output logic [31:0] g_wdata, output logic [31:0] g_maddr,
                          output logic g_rd, output logic g_after);
        int w;
        g_err = 1'b0; g_lat = 0; g_rdata = 32'h0; g_wstrb = 4'h0;
        g_wdata = 32'h0; g_maddr = 32'h0; g_rd = 1'b0; g_after = 1'b0;
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (bus.req_ready) begin
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    bus.req_valid = 1'b0;
                    g_maddr = bus.mem_addr;
                end
                g_wstrb |= bus.mem_wr_strobe;
                if (bus.mem_wr_strobe != 4'h0) g_wdata = bus.mem_wdata;
                g_rd |= bus.mem_rd_strobe;
                if (bus.rsp_valid) begin
                    g_lat = k;
                    g_err = bus.rsp_err;
                    g_rdata = bus.rsp_rdata;
                    break;
                end
            end
            @(negedge clk);
            g_after = bus.rsp_valid;
        end else begin
            bus.req_valid = 1'b0;
        end
        $display("txn we=%0d f3=%0d addr=%08h wdata=%08h -> err=%0d rdata=%08h lat=%0d wstrb=%b",
                 we, f3, addr, wdata, g_err, g_rdata, g_lat, g_wstrb);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_errors++; $display("FAIL reset_rsp valid=%b err=%b required 0 0", bus.rsp_valid, bus.rsp_err);
        end
        n_checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_rdata got %08h required 00000000", bus.rsp_rdata);
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_mem addr=%08h wdata=%08h required 0 0", bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if (bus.mem_wr_strobe !== 4'h0 || bus.mem_rd_strobe !== 1'b0) begin
            n_errors++; $display("FAIL reset_strobes wr=%b rd=%b required 0000 0", bus.mem_wr_strobe, bus.mem_rd_strobe);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_store_word();
        logic e_err, g_err, g_rd, g_after; int e_lat, g_lat;
        logic [31:0] e_rdata, e_wdata, g_rdata, g_wdata, g_maddr; logic [3:0] e_wstrb, g_wstrb;
        model(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, e_err, e_lat, e_rdata, e_wstrb, e_wdata);
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        n_checks++;
        if (g_maddr !== 32'h10 || g_wstrb !== 4'b1111 || g_wdata !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL sw_access addr=%08h wstrb=%b wdata=%08h required 00000010 1111 deadbeef", g_maddr, g_wstrb, g_wdata);
        end
        n_checks++;
        if (g_lat !== 2 || g_err !== 1'b0 || g_after !== 1'b0) begin
            n_errors++; $display("FAIL sw_resp lat=%0d err=%b after=%b required 2 0 0", g_lat, g_err, g_after);
        end
    endtask

    task automatic test_store_byte();
        logic e_err, g_err, g_rd, g_after; int e_lat, g_lat;
        logic [31:0] e_rdata, e_wdata, g_rdata, g_wdata, g_maddr; logic [3:0] e_wstrb, g_wstrb;
        model(1'b1, 3'd0, 32'h13, 32'h000000A5, e_err, e_lat, e_rdata, e_wstrb, e_wdata);
        do_req(1'b1, 3'd0, 32'h13, 32'h000000A5, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        n_checks++;
        if (g_wstrb !== 4'b1000 || g_wdata !== 32'hA5A5A5A5 || g_maddr !== 32'h10) begin
            n_errors++; $display("FAIL sb_access wstrb=%b wdata=%08h addr=%08h required 1000 a5a5a5a5 00000010", g_wstrb, g_wdata, g_maddr);
        end
        n_checks++;
        if (g_rdata !== 32'h0 || g_lat !== 2) begin
            n_errors++; $display("FAIL sb_resp rdata=%08h lat=%0d required 00000000 2", g_rdata, g_lat);
        end
        model(1'b0, 3'd2, 32'h10, 32'h0, e_err, e_lat, e_rdata, e_wstrb, e_wdata);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        n_checks++;
        if (g_rdata !== 32'hA5ADBEEF || g_lat !== 3 || g_rd !== 1'b1) begin
            n_errors++; $display("FAIL lw_after_sb rdata=%08h lat=%0d rd=%b required a5adbeef 3 1", g_rdata, g_lat, g_rd);
        end
    endtask

    task automatic test_load_ext();
        logic e_err, g_err, g_rd, g_after; int e_lat, g_lat;
        logic [31:0] e_rdata, e_wdata, g_rdata, g_wdata, g_maddr; logic [3:0] e_wstrb, g_wstrb;
        logic [2:0]  f3s [0:4];
        logic [31:0] ads [0:4];
        logic [31:0] exps [0:4];
        f3s[0] = 3'd0; ads[0] = 32'h11; exps[0] = 32'hFFFFFF80;
        f3s[1] = 3'd4; ads[1] = 32'h11; exps[1] = 32'h00000080;
        f3s[2] = 3'd1; ads[2] = 32'h12; exps[2] = 32'h00001234;
        f3s[3] = 3'd1; ads[3] = 32'h10; exps[3] = 32'hFFFF8056;
        f3s[4] = 3'd5; ads[4] = 32'h10; exps[4] = 32'h00008056;
        model(1'b1, 3'd2, 32'h10, 32'h12348056, e_err, e_lat, e_rdata, e_wstrb, e_wdata);
        do_req(1'b1, 3'd2, 32'h10, 32'h12348056, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
            n_checks++;
            if (g_rdata !== exps[i] || g_err !== 1'b0 || g_lat !== 3) begin
                n_errors++; $display("FAIL load_ext[%0d] rdata=%08h err=%b lat=%0d required %08h 0 3", i, g_rdata, g_err, g_lat, exps[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic g_err, g_rd, g_after; int g_lat;
        logic [31:0] g_rdata, g_wdata, g_maddr; logic [3:0] g_wstrb;
        do_req(1'b0, 3'd2, 32'h22, 32'h0, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        n_checks++;
        if (g_err !== 1'b1 || g_lat !== 1 || g_rdata !== 32'h0 || g_rd !== 1'b0 || g_wstrb !== 4'h0) begin
            n_errors++; $display("FAIL misaligned_lw err=%b lat=%0d rdata=%08h rd=%b wstrb=%b required 1 1 0 0 0000", g_err, g_lat, g_rdata, g_rd, g_wstrb);
        end
        do_req(1'b1, 3'd1, 32'h21, 32'hCAFE, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        n_checks++;
        if (g_err !== 1'b1 || g_lat !== 1 || g_rdata !== 32'h0 || g_rd !== 1'b0 || g_wstrb !== 4'h0) begin
            n_errors++; $display("FAIL misaligned_sh err=%b lat=%0d rdata=%08h rd=%b wstrb=%b required 1 1 0 0 0000", g_err, g_lat, g_rdata, g_rd, g_wstrb);
        end
    endtask

    task automatic test_illegal_and_hold();
        logic e_err, g_err, g_rd, g_after; int e_lat, g_lat;
        logic [31:0] e_rdata, e_wdata, g_rdata, g_wdata, g_maddr; logic [3:0] e_wstrb, g_wstrb;
        logic [31:0] exp_a, exp_b, got_a, got_b;
        int ready_at, rsp_a_at, rsp_b_at;
        do_req(1'b1, 3'd4, 32'h14, 32'h55, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        n_checks++;
        if (g_err !== 1'b1 || g_lat !== 1 || g_wstrb !== 4'h0) begin
            n_errors++; $display("FAIL illegal_store err=%b lat=%0d wstrb=%b required 1 1 0000", g_err, g_lat, g_wstrb);
        end
        model(1'b0, 3'd2, 32'h10, 32'h0, e_err, e_lat, exp_a, e_wstrb, e_wdata);
        model(1'b0, 3'd4, 32'h13, 32'h0, e_err, e_lat, exp_b, e_wstrb, e_wdata);
        ready_at = 0; rsp_a_at = 0; rsp_b_at = 0; got_a = 32'h0; got_b = 32'h0;
        bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.req_funct3 = 3'd4;
                bus.req_addr = 32'h13;
            end
            if (ready_at != 0 && n == ready_at + 1) bus.req_valid = 1'b0;
            if (bus.rsp_valid && rsp_a_at == 0) begin
                rsp_a_at = n; got_a = bus.rsp_rdata;
            end else if (bus.rsp_valid) begin
                rsp_b_at = n; got_b = bus.rsp_rdata;
                break;
            end
            if (bus.req_ready && ready_at == 0) ready_at = n;
        end
        bus.req_valid = 1'b0;
        $display("txn held pair: ready_at=%0d rsp_a_at=%0d rdata_a=%08h rsp_b_at=%0d rdata_b=%08h",
                 ready_at, rsp_a_at, got_a, rsp_b_at, got_b);
        n_checks++;
        if (ready_at !== 4 || rsp_a_at !== 3) begin
            n_errors++; $display("FAIL hold_ready ready_at=%0d rsp_a_at=%0d required 4 3", ready_at, rsp_a_at);
        end
        n_checks++;
        if (rsp_b_at !== 7 || got_a !== exp_a || got_b !== exp_b) begin
            n_errors++; $display("FAIL hold_second rsp_b_at=%0d a=%08h b=%08h required 7 %08h %08h", rsp_b_at, got_a, got_b, exp_a, exp_b);
        end
    endtask

    task automatic test_reset_mid();
        logic e_err, g_err, g_rd, g_after; int e_lat, g_lat;
        logic [31:0] e_rdata, e_wdata, g_rdata, g_wdata, g_maddr; logic [3:0] e_wstrb, g_wstrb;
        logic saw_rsp;
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_funct3 = 3'd2; bus.req_addr = 32'h30;
        bus.req_wdata = 32'h11223344; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.mem_wr_strobe !== 4'b1111) begin
            n_errors++; $display("FAIL rstmid_access wstrb=%b required 1111", bus.mem_wr_strobe);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_wr_strobe !== 4'h0) begin
            n_errors++; $display("FAIL rstmid_gate wstrb=%b required 0000", bus.mem_wr_strobe);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_ready got %b required 1", bus.req_ready);
        end
        saw_rsp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_rsp |= bus.rsp_valid;
        end
        $display("txn aborted SW 0x30 by reset, response seen=%0d", saw_rsp);
        n_checks++;
        if (saw_rsp !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_no_rsp got %b required 0", saw_rsp);
        end
        model(1'b0, 3'd2, 32'h30, 32'h0, e_err, e_lat, e_rdata, e_wstrb, e_wdata);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
        n_checks++;
        if (g_rdata !== e_rdata || g_rdata !== init_word(12)) begin
            n_errors++; $display("FAIL rstmid_word got %08h required %08h", g_rdata, e_rdata);
        end
    endtask

    task automatic test_random();
        logic e_err, g_err, g_rd, g_after; int e_lat, g_lat;
        logic [31:0] e_rdata, e_wdata, g_rdata, g_wdata, g_maddr; logic [3:0] e_wstrb, g_wstrb;
        logic we; logic [2:0] f3; logic [31:0] addr, wdata;
        for (int t = 0; t < 48; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 63));
            wdata = $urandom;
            model(we, f3, addr, wdata, e_err, e_lat, e_rdata, e_wstrb, e_wdata);
            do_req(we, f3, addr, wdata, g_err, g_lat, g_rdata, g_wstrb, g_wdata, g_maddr, g_rd, g_after);
            n_checks++;
            if (g_err !== e_err || g_lat !== e_lat || g_after !== 1'b0) begin
                n_errors++; $display("FAIL rand[%0d]_resp err=%b lat=%0d after=%b required %b %0d 0", t, g_err, g_lat, g_after, e_err, e_lat);
            end
            n_checks++;
            if (g_rdata !== e_rdata) begin
                n_errors++; $display("FAIL rand[%0d]_rdata got %08h required %08h", t, g_rdata, e_rdata);
            end
            n_checks++;
            if (g_wstrb !== e_wstrb || (e_wstrb != 4'h0 && g_wdata !== e_wdata)) begin
                n_errors++; $display("FAIL rand[%0d]_write wstrb=%b wdata=%08h required %b %08h", t, g_wstrb, g_wdata, e_wstrb, e_wdata);
            end
            n_checks++;
            if (g_rd !== (!e_err && !we) || (!e_err && g_maddr !== {addr[31:2], 2'b00})) begin
                n_errors++; $display("FAIL rand[%0d]_read rd=%b maddr=%08h required %b %08h", t, g_rd, g_maddr, (!e_err && !we), {addr[31:2], 2'b00});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_word(i) >> (8 * b);
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_ext();
        test_misaligned();
        test_illegal_and_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
